e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It consumes the operands and decoded MDU op that the D->E pipeline register delivers.
- It holds the architectural HI/LO registers and models multi-cycle mult/div latency with a busy counter.
- Its busy flag feeds the hazard unit, which stalls and bubbles the D->E register.
- It respects the exception flush (req) so that a flushed instruction never starts an operation or writes HI/LO.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
req  input  1  exception/interrupt flush; the E-stage instruction this cycle is being cancelled
md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
E_RD1  input  32  rs operand (forwarded)
E_RD2  input  32  rt operand (forwarded)
busy  output  1  operation in flight (registered)
start  output  1  combinational; md_op is in 1..4, req=0 and busy=0
HI  output  32  architectural HI (registered)
LO  output  32  architectural LO (registered)

Behaviour:
- Reset (sync, highest priority): HI=0, LO=0, busy=0, internal counter=0, pending results=0. Reset also aborts an in-flight op with no commit.
- States: IDLE (busy=0), RUN (busy=1). A counter cnt holds the remaining cycles.

IDLE behaviour, evaluated at the posedge:
- md_op 1..4, req=0:
  - compute the full result from E_RD1/E_RD2 at this edge into pending_hi/pending_lo;
  - load cnt = MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- md_op 5/6, req=0: HI<=E_RD1 (mthi) or LO<=E_RD1 (mtlo) at this edge; stay IDLE, busy stays 0.
- req=1: md_op is ignored entirely, with no state change.

RUN behaviour:
- cnt decrements each cycle.
- On the edge where cnt==1: HI<=pending_hi, LO<=pending_lo, busy<=0, go to IDLE.
- Latency: a start at edge T makes busy=1 for exactly N cycles. New HI/LO are visible starting the cycle after edge T+N.
- md_op is ignored while busy; the hazard unit guarantees no issue, and the unit does not depend on it.
- req during RUN does not abort. The in-flight op was issued by an older instruction and commits normally.

Arithmetic:
- mult: signed 32x32->64; HI=upper, LO=lower.
- multu: the same, unsigned.
- div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
- divu: unsigned.
- Divisor 0: op runs the full DIV_CYCLES, then HI and LO are left unchanged.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.

Other rules:
- mfhi/mflo are not handled here. They read HI/LO directly and are stalled by the hazard unit while busy|start.
- start is an output only, for the hazard unit. It has no other side effect.

Test Plan:
- Reset, then idle -> HI=0, LO=0, busy=0.
- mult with E_RD1=0xFFFFFFFE (-2), E_RD2=3 at edge T -> busy=1 for edges T+1..T+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO unchanged before commit.
- multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- div with E_RD1=0xFFFFFFF9 (-7), E_RD2=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu x/0 with prior HI=0x11, LO=0x22 -> busy for 10 cycles, then HI=0x11, LO=0x22. Separately, signed 0x80000000/-1 -> LO=0x80000000, HI=0.
- req and mixed events:
  - mthi 0xABCD with req=1 -> HI unchanged, busy=0.
  - div start, then req on cycle 3 -> div still commits at cycle 10.
  - reset on cycle 4 of a mult -> HI=LO=0, busy=0 next cycle, no later commit.
  - mtlo 0x5 while busy -> ignored; LO gets the op result.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit.
// Owns the architectural HI/LO registers. Each mult/div result is computed
// in the issue cycle and held in a pending register. A down-counter then
// models the unit's latency before the result commits to HI/LO.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  md_op,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  output logic        busy,
  output logic        start,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  // Cleared for divide-by-zero so the commit leaves HI/LO untouched.
  logic          pwr_q, pwr_d;

  logic        is_mdop, is_div, sgn;
  logic [63:0] a_x, b_x, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, den, q_mag, r_mag, quo, rem;

  assign is_mdop = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign sgn     = (md_op == OP_MULT) || (md_op == OP_DIV);

  // A single 64-bit product handles both signednesses: the low 64 bits of
  // sign- or zero-extended operands are exact in two's complement.
  assign a_x  = {{32{sgn & E_RD1[31]}}, E_RD1};
  assign b_x  = {{32{sgn & E_RD2[31]}}, E_RD2};
  assign prod = a_x * b_x;

  // Signed division is done on magnitudes, then the signs are restored.
  // 0x80000000 / -1 therefore falls out as 0x80000000 remainder 0.
  assign a_neg = sgn & E_RD1[31];
  assign b_neg = sgn & E_RD2[31];
  assign a_mag = a_neg ? -E_RD1 : E_RD1;
  assign b_mag = b_neg ? -E_RD2 : E_RD2;
  assign den   = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / den;
  assign r_mag = a_mag % den;
  assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  assign busy  = (state_q == S_RUN);
  assign start = is_mdop && !req && (state_q == S_IDLE);
  assign HI    = hi_q;
  assign LO    = lo_q;

  // Next-state: issue or move-to in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    case (state_q)
      S_IDLE: begin
        if (!req) begin
          if (is_mdop) begin
            state_d = S_RUN;
            cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            phi_d   = is_div ? rem : prod[63:32];
            plo_d   = is_div ? quo : prod[31:0];
            pwr_d   = !(is_div && (E_RD2 == 32'd0));
          end else if (md_op == OP_MTHI) begin
            hi_d = E_RD1;
          end else if (md_op == OP_MTLO) begin
            lo_d = E_RD1;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; synchronous reset also aborts any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu: directed ops. Expected HI/LO are queued at issue time,
// and a monitor checks them whenever busy falls.
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, req;
  logic [2:0]  md_op;
  logic [31:0] E_RD1, E_RD2;
  logic        busy, start;
  logic [31:0] HI, LO;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .req(req), .md_op(md_op),
    .E_RD1(E_RD1), .E_RD2(E_RD2), .busy(busy), .start(start),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] expq[$];
  logic [31:0] m_hi, m_lo;
  logic        busy_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a falling busy means a commit (or a reset abort) just happened.
  always @(negedge clk) begin
    logic [63:0] e;
    if (busy_prev && !busy) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_commit: got %h%h expected no commit", HI, LO);
      end else begin
        e = expq.pop_front();
        chk("commit_hilo", {HI, LO}, e);
      end
    end
    busy_prev = busy;
  end

  // Issue an mdu op and count busy cycles. inj: 0 none, 1 req on busy cycle 3,
  // 2 mtlo 5 on busy cycles 2-3, 3 reset on busy cycle 4.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int n, input int inj);
    int cnt = 0;
    bit same = 1'b1;
    req = 1'b0; md_op = op; E_RD1 = a; E_RD2 = b;
    #1 chk({nm, "_start"}, 64'(start), 64'd1);
    expq.push_back({eh, el});
    @(posedge clk); #1;
    md_op = 3'd0; E_RD1 = '0; E_RD2 = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if ({HI, LO} !== {m_hi, m_lo}) same = 1'b0;
      req = (inj == 1 && cnt == 3);
      reset = (inj == 3 && cnt == 4);
      if (inj == 2 && (cnt == 2 || cnt == 3)) begin
        md_op = 3'd6; E_RD1 = 32'h5;
      end else begin
        md_op = 3'd0; E_RD1 = '0;
      end
    end
    req = 1'b0; reset = 1'b0; md_op = 3'd0; E_RD1 = '0;
    chk({nm, "_busy_cycles"}, 64'(cnt), 64'(n));
    chk({nm, "_hold"}, 64'(same), 64'd1);
    m_hi = eh; m_lo = el;
  endtask

  // Single-cycle op that must not make the unit busy (mthi/mtlo or flushed op).
  task automatic quiet(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq);
    md_op = op; E_RD1 = a; E_RD2 = b; req = rq;
    #1 chk({nm, "_start"}, 64'(start), 64'd0);
    @(posedge clk); #1;
    md_op = 3'd0; E_RD1 = '0; E_RD2 = '0; req = 1'b0;
    if (!rq && op == 3'd5) m_hi = a;
    if (!rq && op == 3'd6) m_lo = a;
    @(negedge clk);
    chk({nm, "_hilo"}, {HI, LO}, {m_hi, m_lo});
    chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit idle_ok;
    reset = 1'b1; req = 1'b0; md_op = 3'd0; E_RD1 = '0; E_RD2 = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_hilo", {HI, LO}, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_start", 64'(start), 64'd0);

    run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MC, 0);
    run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, MC, 0);
    run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC, 0);

    quiet("mthi", 3'd5, 32'h11, 32'd0, 1'b0);
    quiet("mtlo", 3'd6, 32'h22, 32'd0, 1'b0);
    run_op("divu_by0", 3'd4, 32'h1234, 32'd0, 32'h11, 32'h22, DC, 0);
    run_op("div_ovf",  3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DC, 0);

    quiet("mthi_req", 3'd5, 32'hABCD, 32'd0, 1'b1);
    quiet("mult_req", 3'd1, 32'd9, 32'd9, 1'b1);

    run_op("div_req_mid",  3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DC, 1);
    run_op("mtlo_in_busy", 3'd1, 32'd7, 32'd6, 32'd0, 32'h2A, MC, 2);
    run_op("mult_reset",   3'd1, 32'd3, 32'd4, 32'd0, 32'd0, 4, 3);

    idle_ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (busy || {HI, LO} !== 64'd0) idle_ok = 1'b0;
    end
    chk("after_reset_no_commit", 64'(idle_ok), 64'd1);
    chk("queue_drained", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
